uart_tx_frame_ctrl: RTL and testbench

UART_TX_FRAME_CTRL -- requirements
Module: uart_tx_frame_ctrl

---
 rtl/uart_tx_frame_ctrl.sv | 132 +++++++++++++
 tb/tb_uart_tx_frame_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_ctrl.sv
// uart_tx_frame_ctrl
//   Serial framer for a UART transmitter. Runs on the baud-rate clock, so
//   each rising edge emits one line bit. Frame: start (0), DATA_WIDTH
//   payload bits LSB first, an optional parity bit, and a stop bit (1).
//   A new frame can be accepted in IDLE and also in STOP, which allows
//   back-to-back frames with no idle gap.
//
//   state  | meaning
//   IDLE   | line high, waiting for Data_Valid
//   START  | start bit (line low)
//   DATA   | payload bits, LSB first, one per cycle
//   PARITY | latched parity bit
//   STOP   | stop bit (line high), may accept the next frame
//
// Ports
//   clk        in   baud-rate clock, one edge per line bit
//   rst        in   asynchronous active-high reset
//   P_DATA     in   parallel payload
//   Data_Valid in   P_DATA is valid this cycle
//   PAR_EN     in   append a parity bit to this frame
//   Par_BIT    in   parity bit for the current P_DATA
//   TX_OUT     out  serial line, idles high
//   Busy       out  a frame is in progress
//   flag_par   out  new data may be accepted this cycle
module uart_tx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  Par_BIT,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic                  flag_par
);

    // Keep the counter at least one bit wide for DATA_WIDTH == 1.
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  par_q, par_d;
    logic                  par_en_q, par_en_d;
    logic                  accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            par_q    <= par_d;
            par_en_q <= par_en_d;
        end
    end

    // flag_par depends on the state register only, so accept has no
    // combinational loop through the outputs.
    assign accept = Data_Valid & flag_par;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        par_d    = par_q;
        par_en_d = par_en_q;

        case (state_q)
            IDLE: begin
                if (accept) state_d = START;
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA: begin
                shift_d = shift_q >> 1;
                if (cnt_q == LAST_BIT) begin
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
                state_d = accept ? START : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Capture only happens in IDLE/STOP because accept is gated by flag_par.
        if (accept) begin
            shift_d  = P_DATA;
            par_d    = Par_BIT;
            par_en_d = PAR_EN;
        end
    end

    always_comb begin
        TX_OUT   = 1'b1;
        Busy     = (state_q != IDLE);
        flag_par = (state_q == IDLE) || (state_q == STOP);
        case (state_q)
            START:   TX_OUT = 1'b0;
            DATA:    TX_OUT = shift_q[0];
            PARITY:  TX_OUT = par_q;
            default: TX_OUT = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Testbench for uart_tx_frame_ctrl (DATA_WIDTH = 8). A frame-level model
// keeps a queue of the line bits still to be sent; a frame may start when
// at most the stop bit remains.
module tb_uart_tx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       Par_BIT;
    logic       TX_OUT;
    logic       Busy;
    logic       flag_par;

    int checks = 0;
    int errors = 0;

    bit exp_q[$];
    logic obs_tx, obs_busy, obs_flag;

    uart_tx_frame_ctrl #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .Par_BIT    (Par_BIT),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy),
        .flag_par   (flag_par)
    );

    always #5 clk = ~clk;

    task automatic push_frame(input logic [7:0] d, input logic pe, input logic pb);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (pe) exp_q.push_back(pb);
        exp_q.push_back(1'b1);
    endtask

    // One baud period: update the model at the edge, then compare outputs.
    task automatic step();
        logic acc;
        logic e_tx, e_busy, e_flag;
        @(posedge clk);
        acc = Data_Valid && (exp_q.size() <= 1);
        if (exp_q.size() > 0) exp_q.delete(0);
        if (acc) push_frame(P_DATA, PAR_EN, Par_BIT);
        #1;
        e_tx   = (exp_q.size() > 0) ? exp_q[0] : 1'b1;
        e_busy = (exp_q.size() > 0);
        e_flag = (exp_q.size() <= 1);
        obs_tx   = TX_OUT;
        obs_busy = Busy;
        obs_flag = flag_par;
        checks++;
        if (TX_OUT !== e_tx) begin
            errors++;
            $display("FAIL tx t=%0t got %b exp %b", $time, TX_OUT, e_tx);
        end
        checks++;
        if (Busy !== e_busy) begin
            errors++;
            $display("FAIL busy t=%0t got %b exp %b", $time, Busy, e_busy);
        end
        checks++;
        if (flag_par !== e_flag) begin
            errors++;
            $display("FAIL flag_par t=%0t got %b exp %b", $time, flag_par, e_flag);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0 || flag_par !== 1'b1) begin
            errors++;
            $display("FAIL %s got tx=%b busy=%b flag=%b exp tx=1 busy=0 flag=1",
                     name, TX_OUT, Busy, flag_par);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        Data_Valid = 1'b0;
        P_DATA = 8'h00;
        PAR_EN = 1'b0;
        Par_BIT = 1'b0;
        #3;
        check_idle_outputs("reset_async");
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_held");
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        step();
        step();
    endtask

    task automatic test_parity_a5();
        logic [0:15] got;
        logic [0:10] exp_bits;
        int busy_cnt;
        exp_bits = 11'b01010010101;
        busy_cnt = 0;
        P_DATA = 8'hA5; PAR_EN = 1'b1; Par_BIT = 1'b0; Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
        got[0] = obs_tx; busy_cnt += int'(obs_busy);
        for (int i = 1; i < 14; i++) begin
            step();
            got[i] = obs_tx;
            busy_cnt += int'(obs_busy);
        end
        checks++;
        if (got[0:10] !== exp_bits) begin
            errors++;
            $display("FAIL a5_frame got %b exp %b", got[0:10], exp_bits);
        end
        checks++;
        if (got[11] !== 1'b1) begin
            errors++;
            $display("FAIL a5_idle got %b exp 1", got[11]);
        end
        checks++;
        if (busy_cnt != 11) begin
            errors++;
            $display("FAIL a5_busy_len got %0d exp 11", busy_cnt);
        end
    endtask

    task automatic test_noparity_0f();
        logic [0:15] got;
        logic [0:9] exp_bits;
        int busy_cnt;
        exp_bits = 10'b0111100001;
        busy_cnt = 0;
        P_DATA = 8'h0F; PAR_EN = 1'b0; Par_BIT = 1'b0; Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
        got[0] = obs_tx; busy_cnt += int'(obs_busy);
        for (int i = 1; i < 13; i++) begin
            step();
            got[i] = obs_tx;
            busy_cnt += int'(obs_busy);
        end
        checks++;
        if (got[0:9] !== exp_bits) begin
            errors++;
            $display("FAIL 0f_frame got %b exp %b", got[0:9], exp_bits);
        end
        checks++;
        if (busy_cnt != 10) begin
            errors++;
            $display("FAIL 0f_busy_len got %0d exp 10", busy_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [0:23] got;
        int busy_cnt;
        logic [7:0] second;
        busy_cnt = 0;
        P_DATA = 8'h55; PAR_EN = 1'b1; Par_BIT = ^8'h55; Data_Valid = 1'b1;
        step();
        got[0] = obs_tx; busy_cnt += int'(obs_busy);
        for (int i = 1; i <= 10; i++) begin
            step();
            got[i] = obs_tx;
            busy_cnt += int'(obs_busy);
        end
        // Now showing the first frame's stop bit.
        P_DATA = 8'h33; Par_BIT = ^8'h33;
        step();
        Data_Valid = 1'b0;
        got[11] = obs_tx; busy_cnt += int'(obs_busy);
        for (int i = 12; i < 24; i++) begin
            step();
            got[i] = obs_tx;
            busy_cnt += int'(obs_busy);
        end
        checks++;
        if (got[10] !== 1'b1 || got[11] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap got stop=%b start=%b exp stop=1 start=0", got[10], got[11]);
        end
        for (int i = 0; i < 8; i++) second[i] = got[12 + i];
        checks++;
        if (second !== 8'h33) begin
            errors++;
            $display("FAIL b2b_data2 got %h exp 33", second);
        end
        checks++;
        if (busy_cnt != 22) begin
            errors++;
            $display("FAIL b2b_busy_len got %0d exp 22", busy_cnt);
        end
    endtask

    task automatic test_ignore_in_flight();
        logic [7:0] d;
        int busy_cnt;
        d = 8'($urandom);
        busy_cnt = 0;
        P_DATA = d; PAR_EN = 1'b1; Par_BIT = ^d; Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
        busy_cnt += int'(obs_busy);
        for (int i = 0; i < 3; i++) begin
            step();
            busy_cnt += int'(obs_busy);
        end
        P_DATA = ~d; PAR_EN = 1'b0; Par_BIT = ~(^d); Data_Valid = 1'b1;
        step();
        busy_cnt += int'(obs_busy);
        Data_Valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            busy_cnt += int'(obs_busy);
        end
        checks++;
        if (busy_cnt != 11) begin
            errors++;
            $display("FAIL ignore_busy_len got %0d exp 11", busy_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        P_DATA = 8'hC3; PAR_EN = 1'b1; Par_BIT = 1'b0; Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        // Fourth data bit (bit 3 of C3 = 0) is on the line now.
        checks++;
        if (obs_tx !== 1'b0 || obs_busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre got tx=%b busy=%b exp tx=0 busy=1", obs_tx, obs_busy);
        end
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("rst_mid_async");
        exp_q.delete();
        // Data_Valid held high across deassertion must be taken at the first edge.
        P_DATA = 8'h96; PAR_EN = 1'b1; Par_BIT = ^8'h96; Data_Valid = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step();
        Data_Valid = 1'b0;
        checks++;
        if (obs_tx !== 1'b0 || obs_busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_first_accept got tx=%b busy=%b exp tx=0 busy=1", obs_tx, obs_busy);
        end
        for (int i = 0; i < 12; i++) step();
    endtask

    task automatic test_parity_latch();
        logic [0:15] got;
        P_DATA = 8'h00; PAR_EN = 1'b1; Par_BIT = 1'b1; Data_Valid = 1'b1;
        step();
        PAR_EN = 1'b0; Par_BIT = 1'b0; P_DATA = 8'hFF; Data_Valid = 1'b0;
        got[0] = obs_tx;
        for (int i = 1; i < 12; i++) begin
            step();
            got[i] = obs_tx;
        end
        checks++;
        if (got[9] !== 1'b1) begin
            errors++;
            $display("FAIL par_latch got %b exp 1", got[9]);
        end
        checks++;
        if (got[1:8] !== 8'h00) begin
            errors++;
            $display("FAIL par_latch_data got %b exp 00000000", got[1:8]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            Data_Valid = ($urandom_range(0, 3) == 0);
            P_DATA = 8'($urandom);
            PAR_EN = 1'($urandom);
            Par_BIT = (^P_DATA) ^ ($urandom_range(0, 7) == 0);
            step();
        end
        Data_Valid = 1'b0;
        for (int i = 0; i < 13; i++) step();
    endtask

    initial begin
        test_reset();
        test_parity_a5();
        test_noparity_0f();
        test_back_to_back();
        test_ignore_in_flight();
        test_reset_mid_frame();
        test_parity_latch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
